// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller.
//   Turns per-stage stall requests into a contiguous stall mask (a stall at
//   stage k freezes stages k..0). A committed exception flushes the pipeline
//   for FLUSH_CYCLES cycles and redirects the PC, either to EXC_VEC or, for an
//   ERET, to the EPC supplied by CP0.
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall/flush
//   performance counters; without it both counter outputs are constant 0.
// Ports:
//   clk            - clock, rising edge
//   resetn         - asynchronous reset, ACTIVE HIGH despite the name
//   stallreq_i     - per-stage stall requests (bit 0 = PC, bit k = stage k)
//   excepttype_i   - committed exception code from MEM, 0 = none
//   epc_i          - EPC from CP0 (ERET target)
//   stall_o        - per-stage hold mask
//   flush_o        - clear all pipeline registers
//   new_pc_o       - redirect target, valid while flush_o = 1
//   busy_o         - 1 while the controller is not in RUN
//   stall_cnt_o    - RUN cycles with a stall request (perf)
//   flush_cnt_o    - number of RUN->FLUSH transitions (perf)
module pipe_ctrl #(
  parameter int          NSTAGE       = 6,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VEC      = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE    = 32'h0000_000e
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       epc_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              busy_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_flush_left;
  logic [3:0]        w_flush_left_nxt;
  logic [31:0]       r_new_pc;
  logic              w_take_exc;
  logic [NSTAGE-1:0] w_stall_map;

  // State register, flush counter and latched redirect target.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state      <= ST_RUN;
      r_flush_left <= 4'd0;
      r_new_pc     <= 32'h0000_0000;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_left <= w_flush_left_nxt;
      if (w_take_exc) begin
        r_new_pc <= (excepttype_i == ERET_CODE) ? epc_i : EXC_VEC;
      end else begin
        r_new_pc <= r_new_pc;
      end
    end
  end

  // Next-state logic: exceptions are only accepted while in RUN.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_left_nxt = r_flush_left;
    w_take_exc       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (excepttype_i != 32'h0000_0000) begin
          w_state_nxt      = ST_FLUSH;
          w_flush_left_nxt = FLUSH_INIT;
          w_take_exc       = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (r_flush_left == 4'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_flush_left_nxt = r_flush_left - 4'd1;
        end
      end
      default: begin
        w_state_nxt      = ST_RUN;
        w_flush_left_nxt = 4'd0;
      end
    endcase
  end

  // Stall mask: every stage at or below the highest requester is held,
  // so younger stages never overrun a stalled older one.
  always_comb begin
    logic acc;
    acc         = 1'b0;
    w_stall_map = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc            = acc | stallreq_i[i];
      w_stall_map[i] = acc;
    end
  end

  // Output decode: flush overrides stall.
  always_comb begin
    stall_o  = '0;
    flush_o  = 1'b0;
    busy_o   = 1'b0;
    case (r_state)
      ST_RUN: begin
        stall_o = w_stall_map;
      end
      ST_FLUSH: begin
        flush_o = 1'b1;
        busy_o  = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  assign new_pc_o = r_new_pc;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if ((r_state == ST_RUN) && (stallreq_i != '0)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_take_exc) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule
